// File: rtl/fpu_mant_sub_pipe_if.sv
// ============================================================================
// Module   : fpu_mant_sub_pipe_if
// Brief    : Operand-in / result-out handshake bundle for fpu_mant_sub_pipe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fpu_mant_sub_pipe_if #(
  parameter int SIZE_DATA = 24
);
  logic                 i_valid;
  logic                 o_ready;
  logic [SIZE_DATA-1:0] i_data_a;
  logic [SIZE_DATA-1:0] i_data_b;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_DATA-1:0] o_diff;
  logic                 o_less;
  logic                 o_zero;

  modport slave (
    input  i_valid, i_data_a, i_data_b, i_ready,
    output o_ready, o_valid, o_diff, o_less, o_zero
  );

  modport master (
    output i_valid, i_data_a, i_data_b, i_ready,
    input  o_ready, o_valid, o_diff, o_less, o_zero
  );
endinterface

`default_nettype wire

// File: rtl/fpu_mant_sub_pipe.sv
// ============================================================================
// Module   : fpu_mant_sub_pipe
// Brief    : 2-stage borrow-lookahead mantissa subtractor giving |A-B|, A<B, A==B.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_mant_sub_pipe #(
  parameter int SIZE_DATA = 24
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst,
  fpu_mant_sub_pipe_if.slave bus
);

  localparam int HALF = SIZE_DATA / 2;
  localparam int NGRP = HALF / 4;

  // Half-width subtract: 4-bit group G/P select each group's borrow-in,
  // bits inside a group ripple from that borrow-in. Returns {borrow_out, diff}.
  function automatic logic [HALF:0] sub_la(input logic [HALF-1:0] a,
                                           input logic [HALF-1:0] b,
                                           input logic            bin);
    logic [HALF-1:0] g, p, d;
    logic [NGRP:0]   gb;
    logic            gg, gp, bc;
    g     = ~a & b;
    p     = ~(a & ~b);
    d     = '0;
    gb    = '0;
    gb[0] = bin;
    for (int k = 0; k < NGRP; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        gg = g[4*k+j] | (p[4*k+j] & gg);
        gp = gp & p[4*k+j];
      end
      gb[k+1] = gg | (gp & gb[k]);
      bc = gb[k];
      for (int j = 0; j < 4; j++) begin
        d[4*k+j] = a[4*k+j] ^ b[4*k+j] ^ bc;
        bc       = g[4*k+j] | (p[4*k+j] & bc);
      end
    end
    return {gb[NGRP], d};
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [HALF-1:0]      dlo_q, dlo_d;
  logic                 blo_q, blo_d;
  logic [HALF-1:0]      ahi_q, ahi_d;
  logic [HALF-1:0]      bhi_q, bhi_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [SIZE_DATA-1:0] diff_q, diff_d;
  logic                 less_q, less_d;
  logic                 zero_q, zero_d;

  logic                 w_s1_adv, w_s2_adv;
  logic [HALF:0]        w_lo, w_hi;
  logic [SIZE_DATA-1:0] w_raw;

  always_comb begin
    w_s2_adv = !s2_valid_q | bus.i_ready;
    w_s1_adv = !s1_valid_q | w_s2_adv;
    w_lo     = sub_la(bus.i_data_a[HALF-1:0], bus.i_data_b[HALF-1:0], 1'b0);
    w_hi     = sub_la(ahi_q, bhi_q, blo_q);
    w_raw    = {w_hi[HALF-1:0], dlo_q};

    s1_valid_d = s1_valid_q;
    dlo_d      = dlo_q;
    blo_d      = blo_q;
    ahi_d      = ahi_q;
    bhi_d      = bhi_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    less_d     = less_q;
    zero_d     = zero_q;

    if (w_s1_adv) begin
      s1_valid_d = bus.i_valid;
      if (bus.i_valid) begin
        dlo_d = w_lo[HALF-1:0];
        blo_d = w_lo[HALF];
        ahi_d = bus.i_data_a[SIZE_DATA-1:HALF];
        bhi_d = bus.i_data_b[SIZE_DATA-1:HALF];
      end
    end

    // Borrow-out of the upper half means A<B; negate raw to get the magnitude.
    if (w_s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = w_hi[HALF] ? (~w_raw + SIZE_DATA'(1)) : w_raw;
        less_d = w_hi[HALF];
        zero_d = (w_raw == '0);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      dlo_q      <= '0;
      blo_q      <= 1'b0;
      ahi_q      <= '0;
      bhi_q      <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      less_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      dlo_q      <= dlo_d;
      blo_q      <= blo_d;
      ahi_q      <= ahi_d;
      bhi_q      <= bhi_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      less_q     <= less_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.o_ready = w_s1_adv;
  assign bus.o_valid = s2_valid_q;
  assign bus.o_diff  = diff_q;
  assign bus.o_less  = less_q;
  assign bus.o_zero  = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_mant_sub_pipe.sv
// ============================================================================
// Module   : tb_fpu_mant_sub_pipe
// Brief    : Directed and randomised self-checking bench for fpu_mant_sub_pipe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpu_mant_sub_pipe;

  localparam int W = 24;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         less;
    logic         zero;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fpu_mant_sub_pipe_if #(.SIZE_DATA(W)) bus ();

  fpu_mant_sub_pipe #(.SIZE_DATA(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  res_t pend;
  bit   rand_rdy = 1'b0;
  bit   in_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t golden(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    r.less = (a < b);
    r.diff = r.less ? (b - a) : (a - b);
    r.zero = (a == b);
    return r;
  endfunction

  // Called at the falling edge: scores the transfers the next rising edge will make.
  task automatic mon();
    res_t r;
    in_acc = bus.i_valid && bus.o_ready;
    if (bus.o_valid && bus.i_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_out observed diff=%0h expected=no output", bus.o_diff);
      end
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("out_diff", 32'(bus.o_diff), 32'(r.diff));
        chk("out_less", 32'(bus.o_less), 32'(r.less));
        chk("out_zero", 32'(bus.o_zero), 32'(r.zero));
      end
    end
    if (in_acc) exp_q.push_back(pend);
  endtask

  task automatic cycle();
    if (rand_rdy) bus.i_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_v(input string tag, input logic exp_valid);
    @(negedge clk);
    chk(tag, 32'(bus.o_valid), 32'(exp_valid));
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
    int n;
    bus.i_valid  = 1'b1;
    bus.i_data_a = a;
    bus.i_data_b = b;
    pend         = e;
    n            = 0;
    do begin
      cycle();
      n++;
    end while (!in_acc && n < 50);
    chk("issue_accept", 32'(in_acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    rand_rdy    = 1'b0;
    n           = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bus.i_valid  = 1'b0;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    bus.i_ready  = 1'b1;
    in_acc       = 1'b0;
    pend         = '0;

    // Reset state
    #12;
    chk("rst_ovalid", 32'(bus.o_valid), 32'd0);
    chk("rst_diff",   32'(bus.o_diff),  32'd0);
    chk("rst_less",   32'(bus.o_less),  32'd0);
    chk("rst_zero",   32'(bus.o_zero),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oready", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1;

    // Two-cycle latency and basic results
    issue(24'h800000, 24'h000001, '{diff: 24'h7FFFFF, less: 1'b0, zero: 1'b0});
    bus.i_valid = 1'b0;
    cycle_v("lat_c1", 1'b0);
    cycle_v("lat_c2", 1'b1);

    issue(24'h000001, 24'hFFFFFF, '{diff: 24'hFFFFFE, less: 1'b1, zero: 1'b0});
    issue(24'hABCDEF, 24'hABCDEF, '{diff: 24'h000000, less: 1'b0, zero: 1'b1});
    issue(24'h001000, 24'h000FFF, '{diff: 24'h000001, less: 1'b0, zero: 1'b0});
    issue(24'h000FFF, 24'h001000, '{diff: 24'h000001, less: 1'b1, zero: 1'b0});
    issue(24'hFFFFFF, 24'h000000, '{diff: 24'hFFFFFF, less: 1'b0, zero: 1'b0});
    issue(24'h000000, 24'hFFFFFF, '{diff: 24'hFFFFFF, less: 1'b1, zero: 1'b0});
    drain();

    // Back-pressure: two entries fill the pipe, third waits, outputs hold
    bus.i_ready = 1'b0;
    issue(24'h000100, 24'h000001, '{diff: 24'h0000FF, less: 1'b0, zero: 1'b0});
    issue(24'h000005, 24'h000009, '{diff: 24'h000004, less: 1'b1, zero: 1'b0});
    bus.i_valid  = 1'b1;
    bus.i_data_a = 24'h123456;
    bus.i_data_b = 24'h123456;
    pend         = '{diff: 24'h000000, less: 1'b0, zero: 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_oready", 32'(bus.o_ready), 32'd0);
      chk("stall_ovalid", 32'(bus.o_valid), 32'd1);
      chk("stall_diff",   32'(bus.o_diff),  32'h0000FF);
      chk("stall_less",   32'(bus.o_less),  32'd0);
      mon();
      @(posedge clk);
      #1;
    end
    bus.i_ready = 1'b1;
    issue(24'h123456, 24'h123456, '{diff: 24'h000000, less: 1'b0, zero: 1'b1});
    drain();

    // Asynchronous reset with both stages full
    bus.i_ready = 1'b0;
    issue(24'h000010, 24'h000003, '{diff: 24'h00000D, less: 1'b0, zero: 1'b0});
    issue(24'h000003, 24'h000010, '{diff: 24'h00000D, less: 1'b1, zero: 1'b0});
    bus.i_valid = 1'b0;
    #2;
    chk("pre_rst_ovalid", 32'(bus.o_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_ovalid", 32'(bus.o_valid), 32'd0);
    chk("async_diff",   32'(bus.o_diff),  32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_oready", 32'(bus.o_ready), 32'd1);
    chk("post_rst_ovalid", 32'(bus.o_valid), 32'd0);
    mon();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cycle();

    // Randomised operands with random valid gaps and random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      issue(ra, rb, golden(ra, rb));
      if ($urandom_range(0, 3) == 0) begin
        bus.i_valid = 1'b0;
        cycle();
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule

`default_nettype wire
